// File: rtl/pixel_out_buffer_if.sv
// Capture/drain bus of the pixel output buffer: GP pixel capture side,
// drain control, and the valid/ready read stream toward the sink.
interface pixel_out_buffer_if #(
  parameter int PW = 18
);
  logic          gp_valid;
  logic [31:0]   gp_pixel;
  logic          drain_req;
  logic          clr;
  logic          rd_ready;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [PW-1:0] rd_addr;
  logic [PW-1:0] pix_count;
  logic          full;
  logic          done;
  logic          overflow;

  modport master (
    output gp_valid, gp_pixel, drain_req, clr, rd_ready,
    input  rd_valid, rd_data, rd_addr, pix_count, full, done, overflow
  );

  modport slave (
    input  gp_valid, gp_pixel, drain_req, clr, rd_ready,
    output rd_valid, rd_data, rd_addr, pix_count, full, done, overflow
  );
endinterface

// File: rtl/pixel_out_buffer.sv
// Frame buffer that captures GP pixels one per cycle, then streams them out
// in index order over a valid/ready port.
//
// state   | meaning
// CAPTURE | accepting GP pixels into the frame
// DRAIN   | streaming captured pixels 0 .. pix_count-1 to the sink
// DONE    | every captured pixel transferred; waiting for clr
module pixel_out_buffer #(
  parameter int NPIX = 153600,
  parameter int PW   = 18
) (
  input logic              clk,
  input logic              rst_n,
  pixel_out_buffer_if.slave bus
);

  localparam int            AW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PW-1:0] NPIX_W = PW'(NPIX);

  typedef enum logic [1:0] {
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [NPIX];
  logic [PW-1:0] pix_count;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    ram_q;
  logic [PW-1:0] q_addr;
  logic          q_vld;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [PW-1:0] rd_addr;
  logic          overflow;

  logic wr_en, xfer, out_load, issue, drop;
  logic unused_hi;

  assign unused_hi = ^bus.gp_pixel[31:8];

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    drop     = 1'b0;
    xfer     = rd_valid && bus.rd_ready;
    out_load = q_vld && (!rd_valid || xfer);
    issue    = 1'b0;
    if (bus.clr) begin
      state_d = CAPTURE;
    end else begin
      case (state_q)
        CAPTURE: begin
          wr_en = bus.gp_valid;
          if (wr_en && (pix_count + PW'(1) == NPIX_W)) begin
            state_d = DRAIN;
          end else if (bus.drain_req) begin
            state_d = (pix_count != '0 || bus.gp_valid) ? DRAIN : DONE;
          end
        end
        DRAIN: begin
          drop  = bus.gp_valid;
          issue = (rd_ptr < pix_count) && (!q_vld || out_load);
          if (xfer && (rd_addr == pix_count - PW'(1))) state_d = DONE;
        end
        DONE: begin
          drop = bus.gp_valid;
        end
        default: state_d = CAPTURE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CAPTURE;
    else        state_q <= state_d;
  end

  // Storage has no reset; a synchronous read feeds the prefetch stage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[pix_count[AW-1:0]] <= bus.gp_pixel[7:0];
    if (issue) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  // Two-deep read pipe: q_* holds the prefetched RAM word, rd_* the presented one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_count <= '0;
      rd_ptr    <= '0;
      q_vld     <= 1'b0;
      q_addr    <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_addr   <= '0;
      overflow  <= 1'b0;
    end else if (bus.clr) begin
      pix_count <= '0;
      rd_ptr    <= '0;
      q_vld     <= 1'b0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) pix_count <= pix_count + PW'(1);
      if (drop)  overflow  <= 1'b1;
      if (issue) begin
        rd_ptr <= rd_ptr + PW'(1);
        q_addr <= rd_ptr;
        q_vld  <= 1'b1;
      end else if (out_load) begin
        q_vld <= 1'b0;
      end
      if (out_load) begin
        rd_valid <= 1'b1;
        rd_data  <= ram_q;
        rd_addr  <= q_addr;
      end else if (xfer) begin
        rd_valid <= 1'b0;
      end
    end
  end

  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_data;
  assign bus.rd_addr   = rd_addr;
  assign bus.pix_count = pix_count;
  assign bus.full      = (pix_count == NPIX_W);
  assign bus.done      = (state_q == DONE);
  assign bus.overflow  = overflow;

endmodule
